instr_fetch_buffer: RTL

//  Fetch stage directly upstream of the single-cycle MIPS core.
//  - Issues word fetches to a variable-latency instruction memory over a req/ack handshake.
//  - Buffers returned words with their PCs in a DEPTH-entry first-word-fall-through FIFO.
//  - Presents instructions to the core with valid/ready.
//  - Handles branch/jump redirects: flushes the buffer and drops in-flight data.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/instr_fetch_buffer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; the low two bits are discarded.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO holding {pc, instr} pairs for the fetch stage.
// Flush has priority over push and pop; head outputs read as zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [31:0]                  wr_pc,
  input  logic [31:0]                  wr_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [31:0]                  head_pc,
  output logic [31:0]                  head_instr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  head_entry;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~flush & (count != FULL_COUNT);
  assign do_pop  = pop & ~flush & (count != {CW{1'b0}});

  // Storage write: only the slot under wr_ptr changes on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {wr_pc, wr_instr};
    end
  end

  // Pointer and occupancy bookkeeping; a flush empties the FIFO in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1'b1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1'b1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Head presentation: forced to zero when empty so stale slots never leak out.
  always_comb begin
    head_entry = mem[rd_ptr];
    if (count != {CW{1'b0}}) begin
      head_pc    = head_entry.pc;
      head_instr = head_entry.instr;
    end else begin
      head_pc    = 32'd0;
      head_instr = 32'd0;
    end
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage ahead of the single-cycle MIPS core: one outstanding word fetch
// over req/ack, a FWFT buffer toward the core, and redirect handling that
// flushes buffered words and discards a fetch still in flight.
// Optional feature macro: FETCH_ALIGN_CHECK_EN adds the sticky o_fetch_err_w
// flag for misaligned redirect targets.
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk_w,
  input  logic        i_rst_w,
  output logic        o_mem_req_w,
  output logic [31:0] o_mem_addr_w,
  input  logic        i_mem_ack_w,
  input  logic [31:0] i_mem_rdata_w,
  output logic        o_instr_valid_w,
  output logic [31:0] o_instr_w,
  output logic [31:0] o_pc_w,
  input  logic        i_instr_ready_w,
  input  logic        i_redirect_w,
  input  logic [31:0] i_redirect_pc_w
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        o_fetch_err_w
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   pc_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  logic          instr_valid;

  // A redirect discards both the returning word and the core's pop.
  assign instr_valid = (count != {CW{1'b0}});
  assign pop         = instr_valid & i_instr_ready_w & ~i_redirect_w;
  assign push        = (state == WAIT) & i_mem_ack_w & ~i_redirect_w;
  assign count_next  = count + CW'(push) - CW'(pop);

  assign o_mem_req_w     = (state == WAIT);
  assign o_mem_addr_w    = fetch_pc;
  assign o_instr_valid_w = instr_valid;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (i_clk_w),
    .rst        (i_rst_w),
    .push       (push),
    .pop        (pop),
    .flush      (i_redirect_w),
    .wr_pc      (fetch_pc),
    .wr_instr   (i_mem_rdata_w),
    .count      (count),
    .head_pc    (o_pc_w),
    .head_instr (o_instr_w)
  );

  // State and fetch address registers.
  always_ff @(posedge i_clk_w or posedge i_rst_w) begin
    if (i_rst_w) begin
      state    <= IDLE;
      fetch_pc <= word_align(RESET_PC);
    end else begin
      state    <= state_next;
      fetch_pc <= pc_next;
    end
  end

  // Next fetch address: redirect target wins, otherwise advance on each accepted word.
  always_comb begin
    if (i_redirect_w) begin
      pc_next = word_align(i_redirect_pc_w);
    end else if (push) begin
      pc_next = fetch_pc + PC_STEP;
    end else begin
      pc_next = fetch_pc;
    end
  end

  // Next-state logic: request only while a free slot will exist after this edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_redirect_w) begin
          state_next = IDLE;
        end else if (count_next < FULL_COUNT) begin
          state_next = WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (i_redirect_w) begin
          if (i_mem_ack_w) begin
            state_next = IDLE;
          end else begin
            state_next = DROP;
          end
        end else if (i_mem_ack_w) begin
          if (count_next < FULL_COUNT) begin
            state_next = WAIT;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = WAIT;
        end
      end
      DROP: begin
        // The stale ack arrives with req low; swallow it and start afresh.
        if (i_mem_ack_w) begin
          state_next = IDLE;
        end else begin
          state_next = DROP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_err;

  // Sticky flag for any redirect whose target is not word aligned.
  always_ff @(posedge i_clk_w or posedge i_rst_w) begin
    if (i_rst_w) begin
      fetch_err <= 1'b0;
    end else if (i_redirect_w && (i_redirect_pc_w[1:0] != 2'b00)) begin
      fetch_err <= 1'b1;
    end else begin
      fetch_err <= fetch_err;
    end
  end

  assign o_fetch_err_w = fetch_err;
`endif

endmodule
